// File: rtl/qpu_ifu_pcgen_pkg.sv
// Shared definitions for the IFU PC generator: widths and the fetch-state encoding.
package qpu_ifu_pcgen_pkg;

  localparam int QPU_PC_SIZE = 32;
  localparam int QPU_XLEN    = 32;
  localparam int IFU_STATE_W = 2;

  // REQ: nothing in flight, WAIT: one fetch in flight, DROP: in-flight fetch is stale
  typedef enum logic [IFU_STATE_W-1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } ifu_state_e;

endpackage

// File: rtl/qpu_ifu_pcgen_dffr.sv
// Generic asynchronous active-low reset flop used for every register in the PC generator.
module qpu_ifu_pcgen_dffr #(
  parameter int             DW      = 1,
  parameter logic [DW-1:0]  RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] i_d,
  output logic [DW-1:0] o_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q <= RST_VAL;
    end else begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/qpu_ifu_pcgen.sv
// Instruction-fetch PC generator: one outstanding fetch, single-entry decode buffer,
// and flush redirection with discard of a stale in-flight response.
module qpu_ifu_pcgen
  import qpu_ifu_pcgen_pkg::*;
#(
  parameter int                   PC_SIZE    = QPU_PC_SIZE,
  parameter int                   INSTR_SIZE = 32,
  parameter logic [PC_SIZE-1:0]   RESET_PC   = '0,
  parameter int                   PC_INCR    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pipe_flush_req,
  output logic                  pipe_flush_ack,
  input  logic [PC_SIZE-1:0]    pipe_flush_add_op1,
  input  logic [PC_SIZE-1:0]    pipe_flush_add_op2,
  output logic                  ifu_req_valid,
  input  logic                  ifu_req_ready,
  output logic [PC_SIZE-1:0]    ifu_req_pc,
  input  logic                  ifu_rsp_valid,
  output logic                  ifu_rsp_ready,
  input  logic [INSTR_SIZE-1:0] ifu_rsp_instr,
  output logic                  ifu_o_valid,
  input  logic                  ifu_o_ready,
  output logic [PC_SIZE-1:0]    ifu_o_pc,
  output logic [INSTR_SIZE-1:0] ifu_o_ir
);

  localparam logic [PC_SIZE-1:0] L_INCR = PC_SIZE'(PC_INCR);

  logic [IFU_STATE_W-1:0] r_state_bits;
  ifu_state_e             r_state;
  ifu_state_e             w_state_nxt;
  logic                   r_rst_done;
  logic [PC_SIZE-1:0]     r_pc, w_pc_nxt;
  logic [PC_SIZE-1:0]     r_fetch_pc, w_fetch_pc_nxt;
  logic                   r_obuf_valid, w_obuf_valid_nxt;
  logic [PC_SIZE-1:0]     r_obuf_pc, w_obuf_pc_nxt;
  logic [INSTR_SIZE-1:0]  r_obuf_ir, w_obuf_ir_nxt;

  logic w_in_req, w_in_wait, w_in_drop;
  logic w_flush_hs, w_req_hs, w_rsp_hs, w_pop, w_load;
  logic [PC_SIZE-1:0] w_flush_pc, w_seq_pc;

  assign r_state   = ifu_state_e'(r_state_bits);
  assign w_in_req  = (r_state == ST_REQ);
  assign w_in_wait = (r_state == ST_WAIT);
  assign w_in_drop = (r_state == ST_DROP);

  // Handshake outputs are held low until the first clock after reset release.
  assign ifu_req_valid  = r_rst_done & w_in_req & ~pipe_flush_req;
  assign ifu_req_pc     = r_pc;
  assign pipe_flush_ack = r_rst_done & ~w_in_drop;
  assign ifu_rsp_ready  = r_rst_done &
                          (w_in_drop | (w_in_wait & (~r_obuf_valid | ifu_o_ready) & ~pipe_flush_req));

  assign ifu_o_valid = r_obuf_valid;
  assign ifu_o_pc    = r_obuf_pc;
  assign ifu_o_ir    = r_obuf_ir;

  assign w_flush_hs = pipe_flush_req & pipe_flush_ack;
  assign w_req_hs   = ifu_req_valid & ifu_req_ready;
  assign w_rsp_hs   = ifu_rsp_valid & ifu_rsp_ready;
  assign w_pop      = r_obuf_valid & ifu_o_ready;
  assign w_load     = w_in_wait & w_rsp_hs;
  assign w_flush_pc = pipe_flush_add_op1 + pipe_flush_add_op2;
  assign w_seq_pc   = r_fetch_pc + L_INCR;

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_fetch_pc_nxt   = r_fetch_pc;
    w_obuf_valid_nxt = r_obuf_valid;
    w_obuf_pc_nxt    = r_obuf_pc;
    w_obuf_ir_nxt    = r_obuf_ir;

    case (r_state)
      ST_REQ: begin
        if (!w_flush_hs && w_req_hs) begin
          w_state_nxt    = ST_WAIT;
          w_fetch_pc_nxt = r_pc;
        end
      end
      ST_WAIT: begin
        // A response arriving with the flush is dropped on the floor, so no DROP needed.
        if (w_flush_hs) begin
          w_state_nxt = ifu_rsp_valid ? ST_REQ : ST_DROP;
        end else if (w_rsp_hs) begin
          w_state_nxt = ST_REQ;
          w_pc_nxt    = w_seq_pc;
        end
      end
      ST_DROP: begin
        if (w_rsp_hs) begin
          w_state_nxt = ST_REQ;
        end
      end
      default: w_state_nxt = ST_REQ;
    endcase

    if (w_flush_hs) begin
      w_pc_nxt = w_flush_pc;
    end

    if (w_flush_hs) begin
      w_obuf_valid_nxt = 1'b0;
    end else if (w_load) begin
      w_obuf_valid_nxt = 1'b1;
      w_obuf_pc_nxt    = r_fetch_pc;
      w_obuf_ir_nxt    = ifu_rsp_instr;
    end else if (w_pop) begin
      w_obuf_valid_nxt = 1'b0;
    end
  end

  qpu_ifu_pcgen_dffr #(.DW(1), .RST_VAL(1'b0)) u_rst_done (
    .clk(clk), .rst_n(rst_n), .i_d(1'b1), .o_q(r_rst_done));

  qpu_ifu_pcgen_dffr #(.DW(IFU_STATE_W), .RST_VAL(ST_REQ)) u_state (
    .clk(clk), .rst_n(rst_n), .i_d(w_state_nxt), .o_q(r_state_bits));

  qpu_ifu_pcgen_dffr #(.DW(PC_SIZE), .RST_VAL(RESET_PC)) u_pc (
    .clk(clk), .rst_n(rst_n), .i_d(w_pc_nxt), .o_q(r_pc));

  qpu_ifu_pcgen_dffr #(.DW(PC_SIZE), .RST_VAL('0)) u_fetch_pc (
    .clk(clk), .rst_n(rst_n), .i_d(w_fetch_pc_nxt), .o_q(r_fetch_pc));

  qpu_ifu_pcgen_dffr #(.DW(1), .RST_VAL(1'b0)) u_obuf_valid (
    .clk(clk), .rst_n(rst_n), .i_d(w_obuf_valid_nxt), .o_q(r_obuf_valid));

  qpu_ifu_pcgen_dffr #(.DW(PC_SIZE), .RST_VAL('0)) u_obuf_pc (
    .clk(clk), .rst_n(rst_n), .i_d(w_obuf_pc_nxt), .o_q(r_obuf_pc));

  qpu_ifu_pcgen_dffr #(.DW(INSTR_SIZE), .RST_VAL('0)) u_obuf_ir (
    .clk(clk), .rst_n(rst_n), .i_d(w_obuf_ir_nxt), .o_q(r_obuf_ir));

endmodule

// File: tb/tb_qpu_ifu_pcgen.sv
// Self-checking bench for qpu_ifu_pcgen: directed scenarios plus a randomized run
// checked against a transaction-level model of fetch/flush behaviour.
module tb_qpu_ifu_pcgen;

  localparam logic [31:0] RST_PC = 32'h0;
  localparam logic [31:0] INCR   = 32'd4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_flush_req;
  logic        pipe_flush_ack;
  logic [31:0] pipe_flush_add_op1, pipe_flush_add_op2;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_req_pc;
  logic        ifu_rsp_valid, ifu_rsp_ready;
  logic [31:0] ifu_rsp_instr;
  logic        ifu_o_valid, ifu_o_ready;
  logic [31:0] ifu_o_pc, ifu_o_ir;

  int errors = 0;
  int checks = 0;

  logic        flushReq, oReady, reqReady;
  logic [31:0] flushOp1, flushOp2;
  int          latency;

  logic        memBusy;
  logic [31:0] memAddr;
  int          memCount;

  logic        mOut, mDoomed;
  logic [31:0] mAddr, mFetchPc;
  logic [63:0] mQ[$];

  logic        sReqValid, sRspValid, sRspReady, sAck, sOValid;
  logic [31:0] sReqPc, sOPc, sOIr;
  logic        eReqValid, eRspReady, eAck, eOValid;
  logic [31:0] eReqPc, eOPc, eOIr;

  qpu_ifu_pcgen dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_flush_req(pipe_flush_req), .pipe_flush_ack(pipe_flush_ack),
    .pipe_flush_add_op1(pipe_flush_add_op1), .pipe_flush_add_op2(pipe_flush_add_op2),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_pc(ifu_req_pc),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_instr(ifu_rsp_instr),
    .ifu_o_valid(ifu_o_valid), .ifu_o_ready(ifu_o_ready), .ifu_o_pc(ifu_o_pc), .ifu_o_ir(ifu_o_ir));

  always #5 clk = ~clk;

  function automatic logic [31:0] instrOf(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h5A5A_C3C3;
  endfunction

  // One clock: drive inputs, sample at negedge, advance memory and reference model
  task automatic applyStimulus();
    logic flushHs, taken, pop;
    if (memBusy && memCount > 0) memCount--;
    ifu_rsp_valid      = memBusy && (memCount == 0);
    ifu_rsp_instr      = ifu_rsp_valid ? instrOf(memAddr) : 32'h0;
    pipe_flush_req     = flushReq;
    pipe_flush_add_op1 = flushOp1;
    pipe_flush_add_op2 = flushOp2;
    ifu_req_ready      = reqReady;
    ifu_o_ready        = oReady;
    @(negedge clk);
    sReqValid = ifu_req_valid;  sReqPc = ifu_req_pc;
    sRspValid = ifu_rsp_valid;  sRspReady = ifu_rsp_ready;
    sAck = pipe_flush_ack;
    sOValid = ifu_o_valid;  sOPc = ifu_o_pc;  sOIr = ifu_o_ir;

    eAck      = !(mOut && mDoomed);
    eReqValid = !mOut && !flushReq;
    eReqPc    = mFetchPc;
    eRspReady = mOut && (mDoomed || ((mQ.size() == 0 || oReady) && !flushReq));
    eOValid   = (mQ.size() != 0);
    eOPc      = eOValid ? mQ[0][63:32] : 32'h0;
    eOIr      = eOValid ? mQ[0][31:0]  : 32'h0;

    if (ifu_rsp_valid && (ifu_rsp_ready || (pipe_flush_req && pipe_flush_ack))) memBusy = 1'b0;
    if (ifu_req_valid && ifu_req_ready) begin
      memBusy = 1'b1; memAddr = ifu_req_pc; memCount = latency;
    end

    flushHs = flushReq && eAck;
    taken   = sRspValid && mOut && (eRspReady || flushHs);
    pop     = eOValid && oReady;
    if (flushHs) begin
      mQ.delete();
      mFetchPc = flushOp1 + flushOp2;
      if (mOut && !taken) mDoomed = 1'b1;
      if (taken) mOut = 1'b0;
    end else begin
      if (pop) void'(mQ.pop_front());
      if (taken) begin
        if (mDoomed) mDoomed = 1'b0;
        else begin
          mQ.push_back({mAddr, instrOf(mAddr)});
          mFetchPc = mAddr + INCR;
        end
        mOut = 1'b0;
      end
    end
    if (eReqValid && reqReady) begin
      mOut = 1'b1; mAddr = mFetchPc;
    end
    @(posedge clk); #1;
  endtask

  task automatic holdReset();
    rst_n = 1'b0;
    flushReq = 1'b0; flushOp1 = 32'h0; flushOp2 = 32'h0;
    oReady = 1'b1; reqReady = 1'b1; latency = 1;
    memBusy = 1'b0; memAddr = 32'h0; memCount = 0;
    mOut = 1'b0; mDoomed = 1'b0; mAddr = 32'h0; mFetchPc = RST_PC; mQ.delete();
    pipe_flush_req = 1'b0; pipe_flush_add_op1 = 32'h0; pipe_flush_add_op2 = 32'h0;
    ifu_req_ready = 1'b1; ifu_rsp_valid = 1'b0; ifu_rsp_instr = 32'h0; ifu_o_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic releaseReset();
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    holdReset();
    ifu_rsp_valid = 1'b1;
    #1;
    checks++; if (ifu_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_valid: got %b expected 0", ifu_req_valid); end
    checks++; if (ifu_rsp_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_ready: got %b expected 0", ifu_rsp_ready); end
    checks++; if (ifu_o_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_o_valid: got %b expected 0", ifu_o_valid); end
    checks++; if (pipe_flush_ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_flush_ack: got %b expected 0", pipe_flush_ack); end
    ifu_rsp_valid = 1'b0;
    releaseReset();
    applyStimulus();
    checks++; if (sReqValid !== 1'b1) begin errors++; $display("[TB] FAIL reset_first_req_valid: got %b expected 1", sReqValid); end
    checks++; if (sReqPc !== RST_PC) begin errors++; $display("[TB] FAIL reset_first_req_pc: got %h expected %h", sReqPc, RST_PC); end
  endtask

  task automatic test_sequential();
    logic [31:0] reqs[$];
    logic [31:0] outPc[$];
    logic [31:0] outIr[$];
    logic [31:0] expPc;
    holdReset(); releaseReset();
    for (int c = 0; c < 20 && outPc.size() < 3; c++) begin
      applyStimulus();
      if (sReqValid && reqReady) reqs.push_back(sReqPc);
      if (sOValid && oReady) begin outPc.push_back(sOPc); outIr.push_back(sOIr); end
    end
    for (int i = 0; i < 3; i++) begin
      expPc = 32'(i) * INCR;
      checks++;
      if (i >= reqs.size() || i >= outPc.size()) begin
        errors++; $display("[TB] FAIL seq_count[%0d]: got reqs=%0d outs=%0d expected >%0d", i, reqs.size(), outPc.size(), i);
      end else begin
        if (reqs[i] !== expPc) begin errors++; $display("[TB] FAIL seq_req_pc[%0d]: got %h expected %h", i, reqs[i], expPc); end
        checks++; if (outPc[i] !== expPc) begin errors++; $display("[TB] FAIL seq_o_pc[%0d]: got %h expected %h", i, outPc[i], expPc); end
        checks++; if (outIr[i] !== instrOf(expPc)) begin errors++; $display("[TB] FAIL seq_o_ir[%0d]: got %h expected %h", i, outIr[i], instrOf(expPc)); end
      end
    end
  endtask

  task automatic test_flush_in_req();
    holdReset(); releaseReset();
    oReady = 1'b0;
    applyStimulus();
    applyStimulus();
    flushReq = 1'b1; flushOp1 = 32'h100; flushOp2 = 32'h20;
    applyStimulus();
    checks++; if (sAck !== 1'b1) begin errors++; $display("[TB] FAIL flushreq_ack: got %b expected 1", sAck); end
    checks++; if (sReqValid !== 1'b0) begin errors++; $display("[TB] FAIL flushreq_no_req: got %b expected 0", sReqValid); end
    checks++; if (sOValid !== 1'b1) begin errors++; $display("[TB] FAIL flushreq_buf_before: got %b expected 1", sOValid); end
    flushReq = 1'b0;
    applyStimulus();
    checks++; if (sReqValid !== 1'b1) begin errors++; $display("[TB] FAIL flushreq_req_valid: got %b expected 1", sReqValid); end
    checks++; if (sReqPc !== 32'h120) begin errors++; $display("[TB] FAIL flushreq_req_pc: got %h expected 00000120", sReqPc); end
    checks++; if (sOValid !== 1'b0) begin errors++; $display("[TB] FAIL flushreq_buf_cleared: got %b expected 0", sOValid); end
  endtask

  task automatic test_flush_in_wait();
    holdReset(); releaseReset();
    latency = 3;
    applyStimulus();
    flushReq = 1'b1; flushOp1 = 32'h200; flushOp2 = 32'h40;
    applyStimulus();
    checks++; if (sAck !== 1'b1) begin errors++; $display("[TB] FAIL flushwait_ack: got %b expected 1", sAck); end
    flushReq = 1'b0;
    applyStimulus();
    checks++; if (sAck !== 1'b0) begin errors++; $display("[TB] FAIL flushwait_drop_ack: got %b expected 0", sAck); end
    applyStimulus();
    checks++; if (sAck !== 1'b0) begin errors++; $display("[TB] FAIL flushwait_drop_ack_rsp: got %b expected 0", sAck); end
    checks++; if (sRspValid !== 1'b1 || sRspReady !== 1'b1) begin errors++; $display("[TB] FAIL flushwait_discard: got valid=%b ready=%b expected 1/1", sRspValid, sRspReady); end
    applyStimulus();
    checks++; if (sAck !== 1'b1) begin errors++; $display("[TB] FAIL flushwait_ack_back: got %b expected 1", sAck); end
    checks++; if (sReqValid !== 1'b1 || sReqPc !== 32'h240) begin errors++; $display("[TB] FAIL flushwait_req: got valid=%b pc=%h expected 1/00000240", sReqValid, sReqPc); end
    checks++; if (sOValid !== 1'b0) begin errors++; $display("[TB] FAIL flushwait_o_valid: got %b expected 0", sOValid); end
  endtask

  task automatic test_flush_coincident();
    holdReset(); releaseReset();
    applyStimulus();
    flushReq = 1'b1; flushOp1 = 32'h300; flushOp2 = 32'h4;
    applyStimulus();
    checks++; if (sAck !== 1'b1 || sRspReady !== 1'b0) begin errors++; $display("[TB] FAIL coinc_hs: got ack=%b rsp_ready=%b expected 1/0", sAck, sRspReady); end
    flushReq = 1'b0;
    applyStimulus();
    checks++; if (sReqValid !== 1'b1 || sReqPc !== 32'h304) begin errors++; $display("[TB] FAIL coinc_req: got valid=%b pc=%h expected 1/00000304", sReqValid, sReqPc); end
    checks++; if (sOValid !== 1'b0) begin errors++; $display("[TB] FAIL coinc_o_valid: got %b expected 0", sOValid); end
    applyStimulus();
    applyStimulus();
    checks++; if (sOValid !== 1'b1 || sOPc !== 32'h304) begin errors++; $display("[TB] FAIL coinc_next_out: got valid=%b pc=%h expected 1/00000304", sOValid, sOPc); end
  endtask

  task automatic test_back_to_back();
    holdReset(); releaseReset();
    oReady = 1'b0;
    applyStimulus(); applyStimulus(); applyStimulus();
    applyStimulus();
    checks++; if (sRspReady !== 1'b0) begin errors++; $display("[TB] FAIL bp_rsp_ready_full: got %b expected 0", sRspReady); end
    applyStimulus();
    checks++; if (sRspReady !== 1'b0 || sOPc !== 32'h0) begin errors++; $display("[TB] FAIL bp_hold: got ready=%b o_pc=%h expected 0/00000000", sRspReady, sOPc); end
    oReady = 1'b1;
    applyStimulus();
    checks++; if (sRspReady !== 1'b1 || sOValid !== 1'b1) begin errors++; $display("[TB] FAIL bp_pop_load: got ready=%b o_valid=%b expected 1/1", sRspReady, sOValid); end
    applyStimulus();
    checks++; if (sOValid !== 1'b1 || sOPc !== 32'h4 || sOIr !== instrOf(32'h4)) begin
      errors++; $display("[TB] FAIL bp_new_entry: got valid=%b pc=%h ir=%h expected 1/00000004/%h", sOValid, sOPc, sOIr, instrOf(32'h4));
    end
  endtask

  task automatic test_wrap();
    logic [31:0] reqs[$];
    holdReset(); releaseReset();
    flushReq = 1'b1; flushOp1 = 32'hFFFF_FFF0; flushOp2 = 32'h20;
    applyStimulus();
    flushReq = 1'b0;
    applyStimulus();
    checks++; if (sReqValid !== 1'b1 || sReqPc !== 32'h10) begin errors++; $display("[TB] FAIL wrap_flush_pc: got valid=%b pc=%h expected 1/00000010", sReqValid, sReqPc); end
    applyStimulus(); applyStimulus();
    flushReq = 1'b1; flushOp1 = 32'hFFFF_FFF0; flushOp2 = 32'hC;
    applyStimulus();
    flushReq = 1'b0;
    for (int c = 0; c < 12 && reqs.size() < 2; c++) begin
      applyStimulus();
      if (sReqValid && reqReady) reqs.push_back(sReqPc);
    end
    checks++;
    if (reqs.size() < 2) begin errors++; $display("[TB] FAIL wrap_seq_count: got %0d expected 2", reqs.size()); end
    else if (reqs[0] !== 32'hFFFF_FFFC || reqs[1] !== 32'h0) begin
      errors++; $display("[TB] FAIL wrap_seq_pc: got %h,%h expected fffffffc,00000000", reqs[0], reqs[1]);
    end
  endtask

  task automatic test_reset_mid_fetch();
    holdReset(); releaseReset();
    latency = 3;
    applyStimulus(); applyStimulus();
    holdReset();
    #1;
    checks++; if (ifu_req_valid !== 1'b0 || ifu_rsp_ready !== 1'b0) begin errors++; $display("[TB] FAIL midreset_outputs: got req=%b rsp_ready=%b expected 0/0", ifu_req_valid, ifu_rsp_ready); end
    releaseReset();
    applyStimulus();
    checks++; if (sReqValid !== 1'b1 || sReqPc !== RST_PC || sAck !== 1'b1) begin
      errors++; $display("[TB] FAIL midreset_restart: got req=%b pc=%h ack=%b expected 1/%h/1", sReqValid, sReqPc, sAck, RST_PC);
    end
  endtask

  task automatic test_random();
    int delivered = 0;
    holdReset(); releaseReset();
    for (int c = 0; c < 2000; c++) begin
      if (!flushReq && $urandom_range(0, 9) == 0) begin
        flushReq = 1'b1;
        flushOp1 = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : $urandom;
        flushOp2 = $urandom_range(0, 255);
      end
      oReady   = ($urandom_range(0, 3) != 0);
      reqReady = ($urandom_range(0, 3) != 0);
      latency  = $urandom_range(1, 3);
      applyStimulus();
      if (flushReq && sAck) flushReq = 1'b0;
      if (sOValid && oReady) delivered++;
      checks++; if (sAck !== eAck) begin errors++; $display("[TB] FAIL rnd_ack@%0d: got %b expected %b", c, sAck, eAck); end
      checks++; if (sReqValid !== eReqValid) begin errors++; $display("[TB] FAIL rnd_req_valid@%0d: got %b expected %b", c, sReqValid, eReqValid); end
      if (eReqValid) begin
        checks++; if (sReqPc !== eReqPc) begin errors++; $display("[TB] FAIL rnd_req_pc@%0d: got %h expected %h", c, sReqPc, eReqPc); end
      end
      checks++; if (sRspReady !== eRspReady) begin errors++; $display("[TB] FAIL rnd_rsp_ready@%0d: got %b expected %b", c, sRspReady, eRspReady); end
      checks++; if (sOValid !== eOValid) begin errors++; $display("[TB] FAIL rnd_o_valid@%0d: got %b expected %b", c, sOValid, eOValid); end
      if (eOValid) begin
        checks++; if (sOPc !== eOPc || sOIr !== eOIr) begin errors++; $display("[TB] FAIL rnd_o_data@%0d: got %h/%h expected %h/%h", c, sOPc, sOIr, eOPc, eOIr); end
      end
    end
    checks++; if (delivered < 50) begin errors++; $display("[TB] FAIL rnd_progress: got %0d expected >=50", delivered); end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_sequential();
    test_flush_in_req();
    test_flush_in_wait();
    test_flush_coincident();
    test_back_to_back();
    test_wrap();
    test_reset_mid_fetch();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
